// File: rtl/usb_device_rx_decoder_pkg.sv
// Shared definitions for the USB device receive decoder: line-state
// encodings, RX state encoding, stuffing/SYNC constants and the PID helper.
package usb_device_rx_decoder_pkg;

    // Raw {D+,D-} encodings of the single-ended line states
    localparam logic [1:0] LINE_SE0_ENC = 2'b00;
    localparam logic [1:0] LINE_SE1_ENC = 2'b11;

    // Run of ones after which a zero is inserted by the transmitter
    localparam int unsigned STUFF_LIMIT    = 6;
    // Minimum decoded zeros (including the J->K start) before the closing 1 of SYNC
    localparam int unsigned SYNC_MIN_ZEROS = 5;

    localparam int unsigned ONES_W     = 3;
    localparam int unsigned ZERO_W     = 3;
    localparam int unsigned BIT_W      = 3;
    localparam int unsigned EOP_W      = 2;
    localparam int unsigned RX_STATE_W = 3;

    typedef enum logic [1:0] {
        LINE_J   = 2'd0,
        LINE_K   = 2'd1,
        LINE_SE0 = 2'd2,
        LINE_SE1 = 2'd3
    } line_e;

    typedef enum logic [RX_STATE_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_SYNC  = 3'd1,
        ST_DATA  = 3'd2,
        ST_EOP   = 3'd3,
        ST_ABORT = 3'd4
    } rx_state_e;

    // A PID byte carries its check nibble as the complement of the type nibble
    function automatic logic pid_ok(input logic [7:0] pid);
        return pid[7:4] == ~pid[3:0];
    endfunction

endpackage

// File: rtl/usb_nrzi_unstuff.sv
// NRZI decoder and bit unstuffer.
// Ports:
//   clock, reset     - bit clock, synchronous active-high reset
//   line             - classified line state of the current sample
//   enable           - packet body is being received (stuffing is tracked)
//   load             - SYNC just completed; its closing 1 starts the ones run
//   bit_c            - decoded NRZI bit (meaningful on J/K samples only)
//   bit_valid_c      - decoded bit is a payload bit (stuffed zeros removed)
//   stuff_err_c      - a 1 arrived where a stuffed zero was required
module usb_nrzi_unstuff
    import usb_device_rx_decoder_pkg::*;
(
    input  logic  clock,
    input  logic  reset,
    input  line_e line,
    input  logic  enable,
    input  logic  load,
    output logic  bit_c,
    output logic  bit_valid_c,
    output logic  stuff_err_c
);

    logic              prev_j;
    logic [ONES_W-1:0] ones;
    logic              is_jk;
    logic              at_limit;

    assign is_jk       = (line == LINE_J) || (line == LINE_K);
    assign bit_c       = ((line == LINE_J) == prev_j);
    assign at_limit    = (ones == ONES_W'(STUFF_LIMIT));
    assign bit_valid_c = enable && is_jk && !at_limit;
    assign stuff_err_c = enable && is_jk && at_limit && bit_c;

    // Last J/K level (idle line is J) and the running count of decoded ones
    always_ff @(posedge clock) begin
        if (reset) begin
            prev_j <= 1'b1;
            ones   <= '0;
        end else begin
            if (is_jk) begin
                prev_j <= (line == LINE_J);
            end
            if (load) begin
                ones <= ONES_W'(1);
            end else if (enable && is_jk) begin
                if (at_limit || !bit_c) begin
                    ones <= '0;
                end else begin
                    ones <= ones + ONES_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/usb_device_rx_decoder.sv
// Device-side USB receive decoder: line classification, NRZI decode, SYNC
// detection, unstuffing, byte assembly, PID strobe, EOP and bus-reset detect.
// Optional PID check nibble verification: define USB_RX_PID_CHECK_EN.
// Ports:
//   clock, reset            - bit clock, synchronous active-high reset
//   J_state, K_state        - {D+,D-} encodings of J and K for the bus speed
//   usb_signals             - sampled {D+,D-}
//   rx_active               - packet in progress (SYNC seen, no EOP/abort yet)
//   rx_data                 - last assembled byte, held until the next rx_valid
//   rx_valid, rx_pid_valid  - byte strobe, and first-byte-of-packet strobe
//   rx_eop, rx_error        - clean end of packet / protocol error strobes
//   usb_reset_det           - SE0 has lasted at least RESET_CYCLES samples
module usb_device_rx_decoder
    import usb_device_rx_decoder_pkg::*;
#(
    parameter int unsigned RESET_CYCLES = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] J_state,
    input  logic [1:0] K_state,
    input  logic [1:0] usb_signals,
    output logic       rx_active,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_pid_valid,
    output logic       rx_eop,
    output logic       rx_error,
    output logic       usb_reset_det
);

    localparam int unsigned RST_W = $clog2(RESET_CYCLES + 1);

    rx_state_e         state, state_d;
    logic [1:0]        sample;
    line_e             line_c;
    logic [ZERO_W-1:0] zero_cnt, zero_d;
    logic [BIT_W-1:0]  bit_cnt, bit_d;
    logic [EOP_W-1:0]  eop_cnt, eop_cnt_d;
    logic              j_cnt, j_cnt_d;
    logic [7:0]        shift, shift_d, data_d, byte_c;
    logic              first_byte, first_d;
    logic              active_d, valid_d, pid_d, eop_d, err_d;
    logic [RST_W-1:0]  se0_run, se0_run_d;
    logic              load_c, bit_c, bit_valid_c, stuff_err_c;

    // Line-state classification of the registered pin sample
    always_comb begin
        line_c = LINE_K;
        if (sample == LINE_SE0_ENC) begin
            line_c = LINE_SE0;
        end else if (sample == LINE_SE1_ENC) begin
            line_c = LINE_SE1;
        end else if (sample == J_state) begin
            line_c = LINE_J;
        end else if (sample == K_state) begin
            line_c = LINE_K;
        end
    end

    usb_nrzi_unstuff u_nrzi_unstuff (
        .clock       (clock),
        .reset       (reset),
        .line        (line_c),
        .enable      (state == ST_DATA),
        .load        (load_c),
        .bit_c       (bit_c),
        .bit_valid_c (bit_valid_c),
        .stuff_err_c (stuff_err_c)
    );

    assign byte_c = {bit_c, shift[7:1]};

    // SE0 run length, saturating at the bus-reset threshold
    always_comb begin
        se0_run_d = '0;
        if (line_c == LINE_SE0) begin
            se0_run_d = (se0_run == RST_W'(RESET_CYCLES)) ? se0_run : se0_run + RST_W'(1);
        end
    end

    // Receive FSM: next state and registered-output values
    always_comb begin
        state_d   = state;
        zero_d    = zero_cnt;
        bit_d     = bit_cnt;
        eop_cnt_d = eop_cnt;
        j_cnt_d   = 1'b0;
        shift_d   = shift;
        data_d    = rx_data;
        first_d   = first_byte;
        active_d  = rx_active;
        valid_d   = 1'b0;
        pid_d     = 1'b0;
        eop_d     = 1'b0;
        err_d     = 1'b0;
        load_c    = 1'b0;

        case (state)
            ST_IDLE: begin
                // A K that decodes to 0 can only follow a J: start of SYNC
                if (line_c == LINE_K && !bit_c) begin
                    state_d = ST_SYNC;
                    zero_d  = ZERO_W'(1);
                end
            end
            ST_SYNC: begin
                if (line_c == LINE_J || line_c == LINE_K) begin
                    if (!bit_c) begin
                        if (zero_cnt != '1) begin
                            zero_d = zero_cnt + ZERO_W'(1);
                        end
                    end else if (zero_cnt >= ZERO_W'(SYNC_MIN_ZEROS)) begin
                        state_d  = ST_DATA;
                        active_d = 1'b1;
                        load_c   = 1'b1;
                        bit_d    = '0;
                        first_d  = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (line_c == LINE_SE1 || stuff_err_c ||
                    (line_c == LINE_SE0 && bit_cnt != '0)) begin
                    err_d    = 1'b1;
                    active_d = 1'b0;
                    state_d  = ST_ABORT;
                end else if (line_c == LINE_SE0) begin
                    state_d   = ST_EOP;
                    eop_cnt_d = EOP_W'(1);
                end else if (bit_valid_c) begin
                    shift_d = byte_c;
                    if (bit_cnt == BIT_W'(7)) begin
                        bit_d   = '0;
                        first_d = 1'b0;
`ifdef USB_RX_PID_CHECK_EN
                        if (first_byte && !pid_ok(byte_c)) begin
                            err_d    = 1'b1;
                            active_d = 1'b0;
                            state_d  = ST_ABORT;
                        end else begin
                            data_d  = byte_c;
                            valid_d = 1'b1;
                            pid_d   = first_byte;
                        end
`else
                        data_d  = byte_c;
                        valid_d = 1'b1;
                        pid_d   = first_byte;
`endif
                    end else begin
                        bit_d = bit_cnt + BIT_W'(1);
                    end
                end
            end
            ST_EOP: begin
                if (line_c == LINE_J) begin
                    eop_d    = 1'b1;
                    active_d = 1'b0;
                    state_d  = ST_IDLE;
                end else if (line_c == LINE_SE0 && eop_cnt != EOP_W'(2)) begin
                    eop_cnt_d = eop_cnt + EOP_W'(1);
                end else begin
                    err_d    = 1'b1;
                    active_d = 1'b0;
                    state_d  = ST_ABORT;
                end
            end
            ST_ABORT: begin
                // Recover only after the line has idled as J for two samples
                if (line_c == LINE_J) begin
                    j_cnt_d = 1'b1;
                    if (j_cnt) begin
                        j_cnt_d = 1'b0;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Pin sample, FSM state and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            sample        <= J_state;
            state         <= ST_IDLE;
            zero_cnt      <= '0;
            bit_cnt       <= '0;
            eop_cnt       <= '0;
            j_cnt         <= 1'b0;
            shift         <= '0;
            first_byte    <= 1'b0;
            se0_run       <= '0;
            rx_active     <= 1'b0;
            rx_data       <= 8'h00;
            rx_valid      <= 1'b0;
            rx_pid_valid  <= 1'b0;
            rx_eop        <= 1'b0;
            rx_error      <= 1'b0;
            usb_reset_det <= 1'b0;
        end else begin
            sample        <= usb_signals;
            state         <= state_d;
            zero_cnt      <= zero_d;
            bit_cnt       <= bit_d;
            eop_cnt       <= eop_cnt_d;
            j_cnt         <= j_cnt_d;
            shift         <= shift_d;
            first_byte    <= first_d;
            se0_run       <= se0_run_d;
            rx_active     <= active_d;
            rx_data       <= data_d;
            rx_valid      <= valid_d;
            rx_pid_valid  <= pid_d;
            rx_eop        <= eop_d;
            rx_error      <= err_d;
            usb_reset_det <= (se0_run_d == RST_W'(RESET_CYCLES));
        end
    end

endmodule

// File: tb/tb_usb_device_rx_decoder.sv
// Directed bench for usb_device_rx_decoder using a small FS transmit model
// (NRZI encode with bit stuffing) and a strobe monitor.
module tb_usb_device_rx_decoder;

    localparam logic [1:0] LJ  = 2'b10;
    localparam logic [1:0] LK  = 2'b01;
    localparam logic [1:0] LS0 = 2'b00;
    localparam logic [1:0] LS1 = 2'b11;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] J_state = LJ;
    logic [1:0] K_state = LK;
    logic [1:0] usb_signals = LJ;
    logic       rx_active;
    logic [7:0] rx_data;
    logic       rx_valid, rx_pid_valid, rx_eop, rx_error, usb_reset_det;

    usb_device_rx_decoder #(.RESET_CYCLES(16)) dut (
        .clock         (clock),
        .reset         (reset),
        .J_state       (J_state),
        .K_state       (K_state),
        .usb_signals   (usb_signals),
        .rx_active     (rx_active),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_pid_valid  (rx_pid_valid),
        .rx_eop        (rx_eop),
        .rx_error      (rx_error),
        .usb_reset_det (usb_reset_det)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Strobe monitor
    int         n_valid, n_pid, n_orphan, n_eop, n_err, n_err_active, n_active;
    logic [7:0] q[$];

    always @(negedge clock) begin
        if (!reset) begin
            if (rx_valid) begin
                n_valid++;
                q.push_back(rx_data);
            end
            if (rx_pid_valid) begin
                if (rx_valid) n_pid++;
                else n_orphan++;
            end
            if (rx_eop) n_eop++;
            if (rx_error) n_err++;
            if (rx_error && rx_active) n_err_active++;
            if (rx_active) n_active++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Transmit model
    logic tx_j    = 1'b1;
    int   tx_ones = 0;
    logic corrupt = 1'b0;

    task automatic put(input logic [1:0] v);
        @(negedge clock);
        usb_signals = v;
    endtask

    task automatic put_level();
        put(tx_j ? LJ : LK);
    endtask

    task automatic idle(input int n);
        repeat (n) put(LJ);
        tx_j = 1'b1;
    endtask

    task automatic send_sync();
        put(LK); put(LJ); put(LK); put(LJ);
        put(LK); put(LJ); put(LK); put(LK);
        tx_j    = 1'b0;
        tx_ones = 1;
    endtask

    task automatic tx_bit(input logic b);
        if (!b) tx_j = ~tx_j;
        put_level();
        tx_ones = b ? tx_ones + 1 : 0;
        if (tx_ones == 6) begin
            if (!corrupt) tx_j = ~tx_j;
            put_level();
            tx_ones = 0;
        end
    endtask

    task automatic tx_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) tx_bit(b[i]);
    endtask

    task automatic tx_eop();
        put(LS0); put(LS0); put(LJ);
        tx_j = 1'b1;
    endtask

    task automatic clear_mon();
        @(posedge clock);
        n_valid = 0; n_pid = 0; n_orphan = 0; n_eop = 0;
        n_err = 0; n_err_active = 0; n_active = 0;
        q.delete();
    endtask

    function automatic logic [7:0] qat(input int i);
        return (q.size() > i) ? q[i] : 8'hxx;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        usb_signals = LJ;
        repeat (3) @(negedge clock);
        total++; if (rx_active !== 1'b0) begin bad++; $display("FAIL reset_active got=%b exp=0", rx_active); end
        total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", rx_data); end
        total++; if ({rx_valid, rx_pid_valid, rx_eop, rx_error} !== 4'b0) begin bad++; $display("FAIL reset_strobes got=%b exp=0000", {rx_valid, rx_pid_valid, rx_eop, rx_error}); end
        total++; if (usb_reset_det !== 1'b0) begin bad++; $display("FAIL reset_det got=%b exp=0", usb_reset_det); end
        reset = 1'b0;
        idle(3);
    endtask

    task automatic test_single_pid();
        clear_mon();
        send_sync();
        tx_byte(8'h69);
        tx_eop();
        @(negedge clock);
        total++; if (rx_eop !== 1'b0) begin bad++; $display("FAIL eop_early got=%b exp=0", rx_eop); end
        @(negedge clock);
        total++; if (rx_eop !== 1'b1) begin bad++; $display("FAIL eop_strobe got=%b exp=1", rx_eop); end
        total++; if (rx_active !== 1'b0) begin bad++; $display("FAIL eop_active got=%b exp=0", rx_active); end
        idle(4);
        total++; if (n_valid !== 1) begin bad++; $display("FAIL pid69_nvalid got=%0d exp=1", n_valid); end
        total++; if (qat(0) !== 8'h69) begin bad++; $display("FAIL pid69_data got=%h exp=69", qat(0)); end
        total++; if (n_pid !== 1 || n_orphan !== 0) begin bad++; $display("FAIL pid69_pid got=%0d/%0d exp=1/0", n_pid, n_orphan); end
        total++; if (n_err !== 0) begin bad++; $display("FAIL pid69_err got=%0d exp=0", n_err); end
        total++; if (n_eop !== 1) begin bad++; $display("FAIL pid69_neop got=%0d exp=1", n_eop); end
        total++; if (rx_data !== 8'h69) begin bad++; $display("FAIL pid69_hold got=%h exp=69", rx_data); end
    endtask

    task automatic test_stuffing();
        clear_mon();
        send_sync();
        tx_byte(8'hC3);
        tx_byte(8'hFF);
        tx_eop();
        idle(4);
        total++; if (n_valid !== 2) begin bad++; $display("FAIL stuff_nvalid got=%0d exp=2", n_valid); end
        total++; if (qat(0) !== 8'hC3) begin bad++; $display("FAIL stuff_byte0 got=%h exp=c3", qat(0)); end
        total++; if (qat(1) !== 8'hFF) begin bad++; $display("FAIL stuff_byte1 got=%h exp=ff", qat(1)); end
        total++; if (n_err !== 0) begin bad++; $display("FAIL stuff_err got=%0d exp=0", n_err); end
        total++; if (n_eop !== 1 || n_pid !== 1) begin bad++; $display("FAIL stuff_eop_pid got=%0d/%0d exp=1/1", n_eop, n_pid); end
    endtask

    task automatic test_stuff_error();
        clear_mon();
        corrupt = 1'b1;
        send_sync();
        tx_byte(8'hC3);
        tx_byte(8'hFF);
        corrupt = 1'b0;
        tx_eop();
        idle(4);
        total++; if (n_err !== 1) begin bad++; $display("FAIL stufferr_err got=%0d exp=1", n_err); end
        total++; if (n_valid !== 1 || qat(0) !== 8'hC3) begin bad++; $display("FAIL stufferr_valid got=%0d/%h exp=1/c3", n_valid, qat(0)); end
        total++; if (n_eop !== 0) begin bad++; $display("FAIL stufferr_eop got=%0d exp=0", n_eop); end
        total++; if (n_err_active !== 0) begin bad++; $display("FAIL stufferr_active got=%0d exp=0", n_err_active); end
    endtask

    task automatic test_pid_check();
        clear_mon();
        send_sync();
        tx_byte(8'h66);
        tx_eop();
        idle(4);
`ifdef USB_RX_PID_CHECK_EN
        total++; if (n_err !== 1) begin bad++; $display("FAIL pidchk_err got=%0d exp=1", n_err); end
        total++; if (n_valid !== 0 || n_pid !== 0) begin bad++; $display("FAIL pidchk_valid got=%0d/%0d exp=0/0", n_valid, n_pid); end
`else
        total++; if (n_err !== 0) begin bad++; $display("FAIL pidchk_err got=%0d exp=0", n_err); end
        total++; if (n_valid !== 1 || qat(0) !== 8'h66 || n_pid !== 1) begin bad++; $display("FAIL pidchk_valid got=%0d/%h/%0d exp=1/66/1", n_valid, qat(0), n_pid); end
`endif
    endtask

    task automatic test_errors();
        // SE1 mid-byte
        clear_mon();
        send_sync(); tx_byte(8'h69); tx_bit(1'b1); tx_bit(1'b0);
        put(LS1);
        idle(4);
        total++; if (n_err !== 1 || n_eop !== 0 || n_valid !== 1) begin bad++; $display("FAIL se1_abort got err=%0d eop=%0d valid=%0d exp=1/0/1", n_err, n_eop, n_valid); end
        // EOP on a partial byte
        clear_mon();
        send_sync(); tx_byte(8'h69); tx_bit(1'b1); tx_bit(1'b0); tx_bit(1'b1);
        tx_eop();
        idle(4);
        total++; if (n_err !== 1 || n_eop !== 0 || n_valid !== 1) begin bad++; $display("FAIL align_abort got err=%0d eop=%0d valid=%0d exp=1/0/1", n_err, n_eop, n_valid); end
        // SE0 lasting three samples
        clear_mon();
        send_sync(); tx_byte(8'h69);
        put(LS0); put(LS0); put(LS0); put(LJ);
        idle(4);
        total++; if (n_err !== 1 || n_eop !== 0) begin bad++; $display("FAIL long_se0 got err=%0d eop=%0d exp=1/0", n_err, n_eop); end
        total++; if (n_err_active !== 0 || rx_active !== 1'b0) begin bad++; $display("FAIL err_active got=%0d/%b exp=0/0", n_err_active, rx_active); end
    endtask

    task automatic test_short_sync();
        clear_mon();
        put(LK); put(LJ); put(LK); put(LK);
        idle(4);
        total++; if (n_active !== 0 || n_valid !== 0) begin bad++; $display("FAIL short_sync got active=%0d valid=%0d exp=0/0", n_active, n_valid); end
    endtask

    task automatic test_bus_reset();
        for (int k = 1; k <= 23; k++) begin
            @(negedge clock);
            total++;
            if (usb_reset_det !== ((k >= 18 && k <= 22) ? 1'b1 : 1'b0)) begin
                bad++;
                $display("FAIL reset_det[%0d] got=%b exp=%b", k, usb_reset_det, (k >= 18 && k <= 22));
            end
            usb_signals = (k <= 20) ? LS0 : LJ;
        end
        tx_j = 1'b1;
        idle(2);
    endtask

    task automatic test_back_to_back();
        clear_mon();
        send_sync(); tx_byte(8'hD2); tx_byte(8'h00); tx_eop();
        send_sync(); tx_byte(8'h4B); tx_byte(8'h3C); tx_eop();
        idle(4);
        total++; if (n_valid !== 4) begin bad++; $display("FAIL b2b_nvalid got=%0d exp=4", n_valid); end
        total++; if ({qat(0), qat(1), qat(2), qat(3)} !== 32'hD2004B3C) begin bad++; $display("FAIL b2b_data got=%h%h%h%h exp=d2004b3c", qat(0), qat(1), qat(2), qat(3)); end
        total++; if (n_pid !== 2 || n_eop !== 2 || n_err !== 0) begin bad++; $display("FAIL b2b_flags got pid=%0d eop=%0d err=%0d exp=2/2/0", n_pid, n_eop, n_err); end
    endtask

    task automatic test_reset_mid_packet();
        send_sync(); tx_bit(1'b1); tx_bit(1'b0); tx_bit(1'b1);
        @(negedge clock);
        total++; if (rx_active !== 1'b1) begin bad++; $display("FAIL mid_active got=%b exp=1", rx_active); end
        reset = 1'b1;
        @(negedge clock);
        total++; if ({rx_active, rx_data, rx_valid, rx_pid_valid, rx_eop, rx_error, usb_reset_det} !== 14'b0) begin bad++; $display("FAIL mid_reset_outs got=%b exp=0", {rx_active, rx_data, rx_valid, rx_pid_valid, rx_eop, rx_error, usb_reset_det}); end
        reset = 1'b0;
        usb_signals = LJ;
        idle(3);
        clear_mon();
        send_sync(); tx_byte(8'h69); tx_byte(8'hA5); tx_eop();
        idle(4);
        total++; if (n_valid !== 2 || qat(0) !== 8'h69 || qat(1) !== 8'hA5) begin bad++; $display("FAIL post_reset_data got=%0d/%h/%h exp=2/69/a5", n_valid, qat(0), qat(1)); end
        total++; if (n_pid !== 1 || n_eop !== 1 || n_err !== 0) begin bad++; $display("FAIL post_reset_flags got pid=%0d eop=%0d err=%0d exp=1/1/0", n_pid, n_eop, n_err); end
    endtask

    initial begin
        test_reset();
        test_single_pid();
        test_stuffing();
        test_stuff_error();
        test_pid_check();
        test_errors();
        test_short_sync();
        test_bus_reset();
        test_back_to_back();
        test_reset_mid_packet();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
